// File: rtl/prime_count_core_if.sv
// Method-call and field-port bundle for prime_count_core.
// The caller side (master) drives requests and field writes; the core (slave) returns status.
interface prime_count_core_if #(
    parameter int WIDTH = 16
);
    logic             run_req;
    logic             run_busy;
    logic [WIDTH-1:0] limit_in;
    logic             limit_we;
    logic [WIDTH-1:0] limit_out;
    logic [WIDTH-1:0] count_out;
    logic [WIDTH-1:0] last_prime_out;
    logic             finish_flag_in;
    logic             finish_flag_we;
    logic             finish_flag_out;

    modport master (
        output run_req, limit_in, limit_we, finish_flag_in, finish_flag_we,
        input  run_busy, limit_out, count_out, last_prime_out, finish_flag_out
    );

    modport slave (
        input  run_req, limit_in, limit_we, finish_flag_in, finish_flag_we,
        output run_busy, limit_out, count_out, last_prime_out, finish_flag_out
    );
endinterface

// File: rtl/prime_count_core.sv
// Counts primes in [2, limit] by trial division; the remainder is formed by
// repeated subtraction, one per cycle, so the core needs no divider.
module prime_count_core #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    prime_count_core_if.slave  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_N_TEST  = 3'd2;
    localparam logic [2:0] S_D_TEST  = 3'd3;
    localparam logic [2:0] S_MOD_SUB = 3'd4;
    localparam logic [2:0] S_NEXT_D  = 3'd5;
    localparam logic [2:0] S_NEXT_N  = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]         r_state;
    logic               r_busy;
    logic [WIDTH-1:0]   r_limit;
    logic [WIDTH-1:0]   r_lim;
    logic [WIDTH-1:0]   r_n;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_r;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   r_last;
    logic               r_finish;

    logic [2*WIDTH-1:0] w_d_wide;
    logic [2*WIDTH-1:0] w_n_wide;
    logic [2*WIDTH-1:0] w_d_sq;
    logic               w_is_prime;

    // Square at double width so d*d > n is exact for every representable n.
    assign w_d_wide   = {{WIDTH{1'b0}}, r_d};
    assign w_n_wide   = {{WIDTH{1'b0}}, r_n};
    assign w_d_sq     = w_d_wide * w_d_wide;
    assign w_is_prime = (w_d_sq > w_n_wide);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_limit  <= '0;
            r_lim    <= '0;
            r_n      <= '0;
            r_d      <= '0;
            r_r      <= '0;
            r_count  <= '0;
            r_last   <= '0;
            r_finish <= 1'b0;
        end else begin
            if (bus.limit_we) begin
                r_limit <= bus.limit_in;
            end

            // Completion beats a field write; the run-start clear beats a field write.
            if (r_state == S_DONE) begin
                r_finish <= 1'b1;
            end else if (r_state == S_INIT) begin
                r_finish <= 1'b0;
            end else if (bus.finish_flag_we) begin
                r_finish <= bus.finish_flag_in;
            end

            // Busy rises the cycle after the request is taken and falls with the finish flag.
            r_busy <= (r_state != S_IDLE) && (r_state != S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (bus.run_req) begin
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_lim   <= r_limit;
                    r_count <= '0;
                    r_last  <= '0;
                    r_n     <= WIDTH'(2);
                    r_state <= (r_limit < WIDTH'(2)) ? S_DONE : S_N_TEST;
                end
                S_N_TEST: begin
                    r_d     <= WIDTH'(2);
                    r_state <= S_D_TEST;
                end
                S_D_TEST: begin
                    if (w_is_prime) begin
                        r_count <= r_count + WIDTH'(1);
                        r_last  <= r_n;
                        r_state <= S_NEXT_N;
                    end else begin
                        r_r     <= r_n;
                        r_state <= S_MOD_SUB;
                    end
                end
                S_MOD_SUB: begin
                    if (r_r >= r_d) begin
                        r_r <= r_r - r_d;
                    end else if (r_r == '0) begin
                        r_state <= S_NEXT_N;
                    end else begin
                        r_state <= S_NEXT_D;
                    end
                end
                S_NEXT_D: begin
                    r_d     <= r_d + WIDTH'(1);
                    r_state <= S_D_TEST;
                end
                S_NEXT_N: begin
                    // Compare before incrementing so an all-ones limit cannot wrap n.
                    if (r_n == r_lim) begin
                        r_state <= S_DONE;
                    end else begin
                        r_n     <= r_n + WIDTH'(1);
                        r_state <= S_N_TEST;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.run_busy        = r_busy;
    assign bus.limit_out       = r_limit;
    assign bus.count_out       = r_count;
    assign bus.last_prime_out  = r_last;
    assign bus.finish_flag_out = r_finish;
endmodule

// File: tb/tb_prime_count_core.sv
// Bench for prime_count_core: table of limits with known prime counts, a result
// scoreboard, and hand-written sequences for reset, rerun and flag-priority cases.
module tb_prime_count_core;
    logic clk;
    logic reset;

    prime_count_core_if #(.WIDTH(16)) bus16 ();
    prime_count_core_if #(.WIDTH(4))  bus4 ();

    prime_count_core #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    prime_count_core #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] limit;
        logic [15:0] exp_count;
        logic [15:0] exp_last;
    } vec_t;

    typedef struct {
        logic [15:0] cnt;
        logic [15:0] last;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic write_limit(input logic [15:0] v);
        bus16.limit_in = v;
        bus16.limit_we = 1'b1;
        tick();
        bus16.limit_we = 1'b0;
    endtask

    task automatic start_pulse();
        bus16.run_req = 1'b1;
        tick();
        bus16.run_req = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] c, input logic [15:0] l);
        exp_t e;
        e.cnt  = c;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(bus16.finish_flag_out === 1'b1 && bus16.run_busy === 1'b0) && cyc < 40000);
        if (cyc >= 40000) begin
            n_run++;
            n_fail++;
            $display("FAIL %s_timeout: got no completion, expected finish within 40000 cycles", name);
        end
    endtask

    task automatic check_result(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL %s_scoreboard: got empty queue, expected a pending result", name);
            return;
        end
        e = sb.pop_front();
        $display("[TB] run %s limit=%0d count=%0d last=%0d finish=%0d", name,
                 bus16.limit_out, bus16.count_out, bus16.last_prime_out, bus16.finish_flag_out);
        check({name, "_count"},  32'(bus16.count_out),      32'(e.cnt));
        check({name, "_last"},   32'(bus16.last_prime_out), 32'(e.last));
        check({name, "_finish"}, 32'(bus16.finish_flag_out), 32'd1);
        check({name, "_busy"},   32'(bus16.run_busy),        32'd0);
    endtask

    initial begin
        vec_t vecs[5];
        int   cyc;

        vecs[0] = '{limit: 16'd10, exp_count: 16'd4, exp_last: 16'd7};
        vecs[1] = '{limit: 16'd0,  exp_count: 16'd0, exp_last: 16'd0};
        vecs[2] = '{limit: 16'd1,  exp_count: 16'd0, exp_last: 16'd0};
        vecs[3] = '{limit: 16'd2,  exp_count: 16'd1, exp_last: 16'd2};
        vecs[4] = '{limit: 16'd13, exp_count: 16'd6, exp_last: 16'd13};

        bus16.run_req = 1'b1;
        bus16.limit_in = '0;
        bus16.limit_we = 1'b0;
        bus16.finish_flag_in = 1'b0;
        bus16.finish_flag_we = 1'b0;
        bus4.run_req = 1'b0;
        bus4.limit_in = '0;
        bus4.limit_we = 1'b0;
        bus4.finish_flag_in = 1'b0;
        bus4.finish_flag_we = 1'b0;

        // Reset held with run_req high.
        reset = 1'b0;
        repeat (3) tick();
        check("rst_busy",   32'(bus16.run_busy),        32'd0);
        check("rst_limit",  32'(bus16.limit_out),       32'd0);
        check("rst_count",  32'(bus16.count_out),       32'd0);
        check("rst_last",   32'(bus16.last_prime_out),  32'd0);
        check("rst_finish", 32'(bus16.finish_flag_out), 32'd0);
        push_exp(16'd0, 16'd0);
        reset = 1'b1;
        tick();
        check("rel_busy_edge1", 32'(bus16.run_busy), 32'd0);
        bus16.run_req = 1'b0;
        tick();
        check("rel_busy_edge2", 32'(bus16.run_busy), 32'd1);
        wait_done("rel");
        check_result("rel");

        // Table of single runs.
        for (int i = 0; i < 5; i++) begin
            write_limit(vecs[i].limit);
            push_exp(vecs[i].exp_count, vecs[i].exp_last);
            start_pulse();
            tick();
            check($sformatf("vec%0d_busy_rise", i), 32'(bus16.run_busy), 32'd1);
            wait_done($sformatf("vec%0d", i));
            check_result($sformatf("vec%0d", i));
            repeat (3) tick();
            check($sformatf("vec%0d_no_rerun", i), 32'(bus16.run_busy), 32'd0);
        end

        // run_req held high: back-to-back runs, flag cleared at the second INIT.
        write_limit(16'd30);
        push_exp(16'd10, 16'd29);
        push_exp(16'd10, 16'd29);
        bus16.run_req = 1'b1;
        tick();
        wait_done("hold1");
        check_result("hold1");
        tick();
        tick();
        check("hold_init_finish", 32'(bus16.finish_flag_out), 32'd0);
        check("hold_init_count",  32'(bus16.count_out),       32'd0);
        wait_done("hold2");
        bus16.run_req = 1'b0;
        check_result("hold2");

        // Limit rewritten mid-run does not disturb the current run.
        write_limit(16'd20);
        push_exp(16'd8, 16'd19);
        start_pulse();
        repeat (20) tick();
        write_limit(16'd100);
        wait_done("midwr");
        check_result("midwr");
        check("midwr_limit_out", 32'(bus16.limit_out), 32'd100);
        push_exp(16'd25, 16'd97);
        start_pulse();
        wait_done("lim100");
        check_result("lim100");

        // Field write of 0 on the DONE cycle loses to completion.
        write_limit(16'd0);
        push_exp(16'd0, 16'd0);
        start_pulse();
        tick();
        bus16.finish_flag_in = 1'b0;
        bus16.finish_flag_we = 1'b1;
        wait_done("doneprio");
        bus16.finish_flag_we = 1'b0;
        check_result("doneprio");

        // Plain field writes of the flag while idle.
        bus16.finish_flag_in = 1'b0;
        bus16.finish_flag_we = 1'b1;
        tick();
        check("flag_wr0", 32'(bus16.finish_flag_out), 32'd0);
        bus16.finish_flag_in = 1'b1;
        tick();
        check("flag_wr1", 32'(bus16.finish_flag_out), 32'd1);
        bus16.finish_flag_we = 1'b0;

        // Reset in the middle of a run aborts it.
        write_limit(16'd50);
        start_pulse();
        repeat (30) tick();
        check("abort_busy_before", 32'(bus16.run_busy), 32'd1);
        reset = 1'b0;
        tick();
        check("abort_busy",   32'(bus16.run_busy),        32'd0);
        check("abort_finish", 32'(bus16.finish_flag_out), 32'd0);
        check("abort_count",  32'(bus16.count_out),       32'd0);
        check("abort_last",   32'(bus16.last_prime_out),  32'd0);
        reset = 1'b1;
        repeat (3) tick();
        check("abort_idle", 32'(bus16.run_busy), 32'd0);
        check("abort_no_finish", 32'(bus16.finish_flag_out), 32'd0);

        // Narrow instance: all-ones limit must terminate without n wrapping.
        bus4.limit_in = 4'd15;
        bus4.limit_we = 1'b1;
        tick();
        bus4.limit_we = 1'b0;
        bus4.run_req = 1'b1;
        tick();
        bus4.run_req = 1'b0;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(bus4.finish_flag_out === 1'b1 && bus4.run_busy === 1'b0) && cyc < 5000);
        if (cyc >= 5000) begin
            n_run++;
            n_fail++;
            $display("FAIL w4_timeout: got no completion, expected finish within 5000 cycles");
        end
        $display("[TB] run w4 limit=15 count=%0d last=%0d finish=%0d",
                 bus4.count_out, bus4.last_prime_out, bus4.finish_flag_out);
        check("w4_count",  32'(bus4.count_out),       32'd6);
        check("w4_last",   32'(bus4.last_prime_out),  32'd13);
        check("w4_finish", 32'(bus4.finish_flag_out), 32'd1);

        if (sb.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
